// File: rtl/hs_pkg.sv
// Shared helpers for the hs_fifo_bus elastic buffer: width derivation and
// parameter legality checks used at elaboration time.
package hs_pkg;

  function automatic int clog2_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2_w(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2_w(depth);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x WIDTH register file for hs_fifo_bus: reset-to-zero, one synchronous
// write port and one asynchronous read port.
module hs_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_fifo_bus.sv
// Single-clock valid/ready elastic queue with registered flags, occupancy
// count and synchronous flush. Full/empty are derived from count alone.
module hs_fifo_bus
  import hs_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int CW      = cnt_width(DEPTH),
  localparam int AW      = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam bit DepthOk = is_pow2(DEPTH);
  localparam bit AfOk    = (AF_LEVEL >= 1) && (AF_LEVEL <= DEPTH);

  if (!DepthOk) begin : g_bad_depth
    $error("hs_fifo_bus: DEPTH must be a power of two >= 2");
  end
  if (!AfOk) begin : g_bad_af
    $error("hs_fifo_bus: AF_LEVEL must lie in 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, out_valid_q, almost_full_q;
  logic          wr_en, rd_en;

  // Handshakes use only registered flags, so no input reaches an output
  // combinationally and out_ready never influences in_ready in-cycle.
  always_comb begin
    wr_en    = in_valid && in_ready_q;
    rd_en    = out_valid_q && out_ready;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= (count_d != CW'(DEPTH));
      out_valid_q   <= (count_d != '0);
      almost_full_q <= (count_d >= CW'(AF_LEVEL));
    end
  end

  hs_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule

// File: tb/tb_hs_fifo_bus.sv
// Bench for hs_fifo_bus: directed scenarios plus random back-pressure, all
// checked every cycle against a queue-based model of the buffer.
module tb_hs_fifo_bus;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n, flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready;
  logic [CW-1:0]    count;
  logic             almost_full;

  int total = 0;
  int bad   = 0;

  // Model: contents as a queue, plus the single registered-ready bit whose
  // value depends on reset history rather than on occupancy alone.
  logic [WIDTH-1:0] exp_q[$];
  bit               m_ready = 1'b0;
  bit               last_acc = 1'b0;
  bit               last_rd = 1'b0;
  logic [WIDTH-1:0] last_rd_data;

  always #5 clk = ~clk;

  hs_fifo_bus #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
    if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
  endtask

  // One clock: inputs are already driven; apply the model at the edge, then
  // compare after the outputs settle.
  task automatic cyc();
    bit wr, rd;
    @(posedge clk);
    wr = in_valid && m_ready;
    rd = out_ready && (exp_q.size() != 0);
    last_acc = 1'b0;
    last_rd  = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_ready = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_ready = 1'b1;
    end else begin
      if (rd) begin
        last_rd      = 1'b1;
        last_rd_data = exp_q.pop_front();
      end
      if (wr) begin
        exp_q.push_back(in_data);
        last_acc = 1'b1;
      end
      m_ready = (exp_q.size() != DEPTH);
    end
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    in_data = '0;
    idle_inputs();

    // Reset/idle: three cycles in reset, then the release edge.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    cyc();
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_no_write", 32'(count), 32'd0);
    chk("release_out_data", out_data, 32'd0);
    in_valid = 1'b0;
    cyc();

    // Fill/drain with literal expectations.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      cyc();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 32'hBB;
    cyc();
    chk("full_ignore", 32'(count), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", out_data, 32'hA0 + 32'(i));
      cyc();
    end
    chk("drain_count", 32'(count), 32'd0);
    out_ready = 1'b0;
    cyc();

    // Streaming: 100 words with both sides always ready.
    begin
      int n_out = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 101; i++) begin
        in_data  = 32'h1000 + 32'(i);
        in_valid = (i < 100);
        cyc();
        if (last_rd) begin
          chk("stream_data", last_rd_data, 32'h1000 + 32'(n_out));
          n_out++;
        end
        if (i >= 1 && i < 100) begin
          chk("stream_count", 32'(count), 32'd1);
          chk("stream_no_bubble", 32'(last_rd), 32'd1);
        end
      end
      chk("stream_words", 32'(n_out), 32'd100);
      idle_inputs();
      cyc();
    end

    // Full with a simultaneous read: read happens, write is refused.
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 32'hC0 + 32'(i);
      cyc();
    end
    in_data   = 32'hCC;
    out_ready = 1'b1;
    cyc();
    chk("fullrd_count", 32'(count), 32'd3);
    chk("fullrd_in_ready", 32'(in_ready), 32'd1);
    chk("fullrd_head", out_data, 32'hC1);
    out_ready = 1'b0;
    cyc();
    chk("fullrd_late_write", 32'(count), 32'd4);
    drain();

    // Flush together with a write and a read.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hE0 + 32'(i);
      cyc();
    end
    flush     = 1'b1;
    in_data   = 32'hEE;
    out_ready = 1'b1;
    cyc();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    flush     = 1'b0;
    out_ready = 1'b0;
    in_data   = 32'h55;
    cyc();
    in_valid = 1'b0;
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_data", out_data, 32'h55);
    drain();

    // Reset in mid-operation clears contents and storage.
    in_valid = 1'b1;
    in_data  = 32'h77;
    cyc();
    cyc();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Random back-pressure; in_data held stable until accepted.
    in_valid = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    drain();
    chk("final_empty", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_fifo_bus.md
# hs_fifo_bus

Single-clock, parametrised valid/ready buffer. It is the synchronous-domain successor to our two-phase bit-synchronised handshake bus: it replaces the one-word, one-transfer-in-flight scheme with a DEPTH-entry elastic queue. Both ports sustain one transfer per cycle, and the block adds occupancy reporting and a synchronous flush. It sits between same-clock producer/consumer stages, and on either side of CDC blocks to absorb back-pressure.

## Interface
- WIDTH, 32, data bits per transfer (>=1)
- DEPTH, 4, entries; power of two, >=2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- Derived: CW = $clog2(DEPTH+1) (count width), AW = $clog2(DEPTH) (pointer width)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents; storage values untouched
- in_data  in  WIDTH  producer data
- in_valid  in  1  producer has data
- in_ready  out  1  block accepts data this cycle (registered)
- out_data  out  WIDTH  head entry
- out_valid  out  1  head entry valid (registered)
- out_ready  in  1  consumer takes head this cycle
- count  out  CW  current occupancy 0..DEPTH (registered)
- almost_full  out  1  count >= AF_LEVEL (registered)

## Operation
- Write: in_valid && in_ready at an edge. in_data is stored at wr_ptr, and wr_ptr increments mod DEPTH.
- Read: out_valid && out_ready at an edge. rd_ptr increments mod DEPTH.
- out_data = storage[rd_ptr]. It is meaningful only while out_valid=1 and holds stable while out_valid=1 && out_ready=0.
- Producer rule: once in_valid is raised, in_data must not change until accepted. The block does not check this.
- count_next = count + wr - rd. A simultaneous write and read leaves count unchanged.
- in_ready is a register: in_ready <= (count_next != DEPTH). out_valid <= (count_next != 0). almost_full <= (count_next >= AF_LEVEL).
- in_ready does not depend on out_ready. When full, a same-cycle read does not enable a write; in_ready rises on the following cycle.
- Pointers wrap mod DEPTH, with no extra wrap bit; full/empty come from count only.
- flush=1 at an edge:
  - rd_ptr, wr_ptr and count go to 0, out_valid goes to 0, and in_ready goes to 1.
  - A concurrent write or read is discarded.
  - The flush has no effect on storage.
- No overflow or underflow is possible through the handshake. Writes while in_ready=0 are ignored, and reads while out_valid=0 are ignored.

## Timing
- Reset (rst_n=0 at an edge): in_ready=0, out_valid=0, count=0, almost_full=0 (1 if AF_LEVEL=0; AF_LEVEL is disallowed), pointers=0, all storage=0, so out_data=0.
- First edge with rst_n=1: in_ready=1. No write is accepted on that edge, because in_ready was 0 during it.
- Reset asserted mid-operation: all contents are lost at the next edge, and outputs take the reset values above.
- Latency: a word written at edge k into an empty queue gives out_valid=1 with that out_data in cycle k+1 (1-cycle fall-through).
- Throughput: 1 word/cycle sustained when both sides are always ready, at any occupancy from 1 to DEPTH-1.
- No combinational path from in_* to out_* or from out_ready to in_ready.

## Structure
- Shared package hs_pkg: function for CW/AW computation (clog2 wrapper), and a localparam check that DEPTH is a power of two (elaboration error otherwise).
- One sub-module, hs_fifo_mem: DEPTH x WIDTH register file, reset-to-zero, one write port, one asynchronous read port.
- Top holds the pointers, count and flag registers.
- Expected size: about 150-200 lines RTL.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release. Required: in_ready 0 while rst_n=0 and 1 after the first edge; out_valid=0, count=0, out_data=0.
- Fill/drain, DEPTH=4: write 0xA0..0xA3 with out_ready=0.
  - Required after the fills: count 1,2,3,4; almost_full at count 3; in_ready=0 after the 4th write; a 5th in_valid is ignored.
  - Then set out_ready=1. Required: 0xA0..0xA3 in order, and count returns to 0.
- Streaming: in_valid=out_ready=1 for 100 cycles, incrementing data. Required: 100 words out in order, count constant at 1, no bubbles after the first.
- Full + simultaneous read: at count=4, assert in_valid and out_ready for one cycle. Required: the read happens, count=3, the write is not taken that cycle, and in_ready=1 the next cycle.
- Flush: at count=3, assert flush together with in_valid and out_ready. Required: next cycle count=0, out_valid=0, in_ready=1; a subsequent write of 0x55 emerges as the first output.
- Random back-pressure: random in_valid and out_ready at 50% for 10k cycles against a scoreboard model. Required: no loss, no duplication, order preserved, and count always equal to accepted minus delivered.
